bridge_n_1_arb: RTL and testbench

- Parametrised successor of the static 2:1 SRAM-like mux: N masters (req/wr/size/addr/wdata, rdata/addr_ok/data_ok) share one SRAM-like slave port toward the AXI wrapper.
- Grants are arbitrated; the grant is held until addr_ok is returned.
- Each accepted request's master ID is pushed into an ordering FIFO, so data_ok/rdata return in order to the right master.
- Sits between cache/uncached paths (I$, D$, uncached D) and the SRAM-to-AXI wrapper.

---
 rtl/bridge_pkg.sv | 22 ++
 rtl/bridge_route_fifo.sv | 53 +++++
 rtl/bridge_n_1_arb.sv | 162 ++++++++++++++++
 tb/tb_bridge_n_1_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants and helpers for the N:1 SRAM-like bridge.
// Access sizes, a constant-safe clog2, and the master ID type.
package bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Up to 8 masters fit in a 3-bit ID.
    localparam int MAX_IDW = 3;
    typedef logic [MAX_IDW-1:0] mst_id_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bridge_route_fifo.sv
// Purpose: ID-only FIFO remembering which master owns each accepted request.
// Latency: dout shows the head entry combinationally; push/pop take effect at the clock edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module bridge_route_fifo
    import bridge_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    localparam int PW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !rd_en)      count <= count + CW'(1);
            else if (rd_en && !wr_en) count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/bridge_n_1_arb.sv
// Purpose: N masters share one SRAM-like slave port; grant held until addr_ok, responses routed in order.
// Latency: zero-cycle request/addr_ok/data_ok paths; routing ID stored at accept. ARB_RR_EN selects round-robin.
// Backpressure: s_req withheld while OUTST requests are outstanding; stalled grant is locked until accepted.
module bridge_n_1_arb
    import bridge_pkg::*;
#(
    parameter int N_MST = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int OUTST = 4,
    localparam int IDW  = (clog2(N_MST) < 1) ? 1 : clog2(N_MST),
    localparam int CW   = clog2(OUTST) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MST-1:0]    m_req,
    input  logic [N_MST-1:0]    m_wr,
    input  logic [2*N_MST-1:0]  m_size,
    input  logic [AW*N_MST-1:0] m_addr,
    input  logic [DW*N_MST-1:0] m_wdata,
    output logic [DW*N_MST-1:0] m_rdata,
    output logic [N_MST-1:0]    m_addr_ok,
    output logic [N_MST-1:0]    m_data_ok,
    output logic                s_req,
    output logic                s_wr,
    output logic [1:0]          s_size,
    output logic [AW-1:0]       s_addr,
    output logic [DW-1:0]       s_wdata,
    input  logic [DW-1:0]       s_rdata,
    input  logic                s_addr_ok,
    input  logic                s_data_ok,
    output logic [CW-1:0]       outst_cnt,
    output logic                err_unexp
);

    logic           lock_vld;
    logic [IDW-1:0] lock_id;
    logic           cand_vld;
    logic [IDW-1:0] cand_id;
    logic           gnt_vld;
    logic [IDW-1:0] grant;
    logic           gnt_req;
    logic           full;
    logic           empty;
    logic [IDW-1:0] head_id;
    logic           push;
    logic           pop;

`ifdef ARB_RR_EN
    logic [IDW-1:0] rr_ptr;

    // Pick the requester closest (cyclically) after the last accepted master.
    always_comb begin
        int dist;
        int best_dist;
        cand_vld  = 1'b0;
        cand_id   = '0;
        dist      = 0;
        best_dist = 0;
        for (int i = 0; i < N_MST; i++) begin
            dist = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + N_MST - int'(rr_ptr));
            if (m_req[i] && (!cand_vld || dist < best_dist)) begin
                cand_vld  = 1'b1;
                cand_id   = IDW'(i);
                best_dist = dist;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (grant == IDW'(N_MST - 1)) ? '0 : grant + IDW'(1);
        end
    end
`else
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        for (int i = N_MST - 1; i >= 0; i--) begin
            if (m_req[i]) begin
                cand_vld = 1'b1;
                cand_id  = IDW'(i);
            end
        end
    end
`endif

    assign gnt_vld = ~rst & (lock_vld | cand_vld);
    assign grant   = lock_vld ? lock_id : cand_id;

    always_comb begin
        gnt_req = 1'b0;
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (gnt_vld && grant == IDW'(i)) begin
                gnt_req = m_req[i];
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_addr  = m_addr[AW*i +: AW];
                s_wdata = m_wdata[DW*i +: DW];
            end
        end
    end

    // full uses the registered count: a same-cycle pop does not free a slot.
    assign s_req = gnt_req & ~full;
    assign push  = s_req & s_addr_ok;
    assign pop   = ~rst & s_data_ok & ~empty;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        m_rdata   = '0;
        for (int i = 0; i < N_MST; i++) begin
            m_addr_ok[i] = push & (grant == IDW'(i));
            if (pop && head_id == IDW'(i)) begin
                m_data_ok[i]           = 1'b1;
                m_rdata[DW*i +: DW]    = s_rdata;
            end
        end
    end

    // A dropped request leaves s_req low, which releases the lock on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else begin
            lock_vld <= s_req & ~s_addr_ok;
            lock_id  <= grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_unexp <= 1'b0;
        end else if (s_data_ok && empty) begin
            err_unexp <= 1'b1;
        end
    end

    bridge_route_fifo #(
        .WIDTH (IDW),
        .DEPTH (OUTST)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (grant),
        .dout  (head_id),
        .full  (full),
        .empty (empty),
        .count (outst_cnt)
    );

endmodule

// File: tb/tb_bridge_n_1_arb.sv
// Purpose: directed stimulus for bridge_n_1_arb with a queue-based scoreboard on addr_ok/data_ok.
// Latency: expectations are queued at issue and popped by a negedge monitor when the DUT responds.
// Backpressure: the bench plays the slave, stalling addr_ok and data_ok by hand.
module tb_bridge_n_1_arb;
    import bridge_pkg::*;

    localparam int N     = 3;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int OUTST = 4;
    localparam int CW    = 3;

    logic              clk;
    logic              rst;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_wr;
    logic [2*N-1:0]    m_size;
    logic [AW*N-1:0]   m_addr;
    logic [DW*N-1:0]   m_wdata;
    logic [DW*N-1:0]   m_rdata;
    logic [N-1:0]      m_addr_ok;
    logic [N-1:0]      m_data_ok;
    logic              s_req;
    logic              s_wr;
    logic [1:0]        s_size;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW-1:0]     s_rdata;
    logic              s_addr_ok;
    logic              s_data_ok;
    logic [CW-1:0]     outst_cnt;
    logic              err_unexp;

    typedef struct {
        mst_id_t     id;
        logic [31:0] val;
    } exp_t;

    exp_t exp_aq[$];
    exp_t exp_dq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    bridge_n_1_arb #(.N_MST(N), .AW(AW), .DW(DW), .OUTST(OUTST)) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .s_req     (s_req),
        .s_wr      (s_wr),
        .s_size    (s_size),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_addr_ok (s_addr_ok),
        .s_data_ok (s_data_ok),
        .outst_cnt (outst_cnt),
        .err_unexp (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_addr_ok != '0) begin
                if (exp_aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL addr_ok_unexpected: got %0h expected none", m_addr_ok);
                end else begin
                    mon_e = exp_aq.pop_front();
                    chk("addr_ok_master", m_addr_ok, N'(1) << mon_e.id);
                    chk("addr_ok_s_addr", s_addr, mon_e.val);
                end
            end
            if (m_data_ok != '0) begin
                if (exp_dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data_ok_unexpected: got %0h expected none", m_data_ok);
                end else begin
                    mon_e = exp_dq.pop_front();
                    chk("data_ok_master", m_data_ok, N'(1) << mon_e.id);
                    chk("data_ok_rdata", m_rdata, (DW*N)'(mon_e.val) << (int'(mon_e.id) * DW));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int i, input logic wr, input logic [31:0] a, input logic [1:0] sz);
        m_req[i]             = 1'b1;
        m_wr[i]              = wr;
        m_size[2*i +: 2]     = sz;
        m_addr[AW*i +: AW]   = a;
        m_wdata[DW*i +: DW]  = a ^ 32'h5A5A_5A5A;
    endtask

    task automatic drop(input int i);
        m_req[i]             = 1'b0;
        m_wr[i]              = 1'b0;
        m_size[2*i +: 2]     = '0;
        m_addr[AW*i +: AW]   = '0;
        m_wdata[DW*i +: DW]  = '0;
    endtask

    task automatic exp_acc(input int id, input logic [31:0] a, input logic [31:0] rd);
        exp_t e;
        e.id  = mst_id_t'(id);
        e.val = a;
        exp_aq.push_back(e);
        e.val = rd;
        exp_dq.push_back(e);
    endtask

    task automatic data(input logic [31:0] v);
        s_data_ok = 1'b1;
        s_rdata   = v;
        cyc();
        s_data_ok = 1'b0;
        s_rdata   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        int rr_id;
        rst = 1'b1;
        m_req = '0; m_wr = '0; m_size = '0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        req(0, 1'b0, 32'h1234, SIZE_WORD);
        repeat (2) cyc();
        chk("rst_s_req", s_req, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m_addr_ok", m_addr_ok, 0);
        chk("rst_m_data_ok", m_data_ok, 0);
        chk("rst_outst_cnt", outst_cnt, 0);
        chk("rst_err_unexp", err_unexp, 0);
        drop(0); s_addr_ok = 1'b0; s_data_ok = 1'b0; rst = 1'b0;
        cyc();

        // Single master read with a 2-cycle addr stall and late data.
        req(1, 1'b0, 32'h1000, SIZE_HALF);
        #1;
        chk("s1_s_req", s_req, 1);
        chk("s1_s_addr", s_addr, 32'h1000);
        chk("s1_s_size", s_size, SIZE_HALF);
        cyc(); cyc();
        s_addr_ok = 1'b1; exp_acc(1, 32'h1000, 32'hDEAD_BEEF);
        cyc();
        drop(1); s_addr_ok = 1'b0;
        #1 chk("s1_cnt_one", outst_cnt, 1);
        cyc(); cyc();
        data(32'hDEAD_BEEF);
        #1 chk("s1_cnt_zero", outst_cnt, 0);

        // Lock on m0 while m1 waits.
        req(0, 1'b0, 32'h2000, SIZE_WORD);
        req(1, 1'b0, 32'h3000, SIZE_WORD);
        for (int k = 0; k < 4; k++) begin
            #1 chk("s2_lock_addr", s_addr, 32'h2000);
            cyc();
        end
        s_addr_ok = 1'b1; exp_acc(0, 32'h2000, 32'h1111_1111);
        cyc();
        drop(0);
        #1 chk("s2_m1_after", s_addr, 32'h3000);
        exp_acc(1, 32'h3000, 32'h2222_2222);
        cyc();
        drop(1); s_addr_ok = 1'b0;

        // A higher-priority master arriving during a stall must not steal the grant.
        req(1, 1'b0, 32'h4000, SIZE_WORD);
        cyc();
        req(0, 1'b0, 32'h5000, SIZE_WORD);
        for (int k = 0; k < 2; k++) begin
            #1 chk("s2b_lock_hold", s_addr, 32'h4000);
            cyc();
        end
        s_addr_ok = 1'b1; exp_acc(1, 32'h4000, 32'h3333_3333);
        cyc();
        drop(1);
        #1 chk("s2b_next_grant", s_addr, 32'h5000);
        exp_acc(0, 32'h5000, 32'h4444_4444);
        cyc();
        drop(0); s_addr_ok = 1'b0;
        data(32'h1111_1111); data(32'h2222_2222); data(32'h3333_3333); data(32'h4444_4444);

        // Ordering: m0 read, m1 read, m0 write back-to-back.
        s_addr_ok = 1'b1;
        req(0, 1'b0, 32'hA0, SIZE_WORD); exp_acc(0, 32'hA0, 32'h100);
        cyc();
        drop(0); req(1, 1'b0, 32'hB0, SIZE_WORD); exp_acc(1, 32'hB0, 32'h101);
        cyc();
        drop(1); req(0, 1'b1, 32'hC0, SIZE_BYTE);
        #1;
        chk("s3_s_wr", s_wr, 1);
        chk("s3_s_size", s_size, SIZE_BYTE);
        chk("s3_s_wdata", s_wdata, 32'hC0 ^ 32'h5A5A_5A5A);
        exp_acc(0, 32'hC0, 32'h102);
        cyc();
        drop(0); s_addr_ok = 1'b0;
        data(32'h100); data(32'h101); data(32'h102);

        // Full: four accepted, fifth held until a slot frees on the registered count.
        s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req(0, 1'b0, 32'h40 + k, SIZE_WORD);
            exp_acc(0, 32'h40 + k, 32'h200 + k);
            cyc();
        end
        drop(0); s_addr_ok = 1'b0; req(1, 1'b0, 32'h50, SIZE_WORD);
        #1;
        chk("s4_full_s_req", s_req, 0);
        chk("s4_full_cnt", outst_cnt, 4);
        cyc();
        s_data_ok = 1'b1; s_rdata = 32'h200;
        #1 chk("s4_pop_same_cycle_s_req", s_req, 0);
        cyc();
        s_data_ok = 1'b0; s_rdata = '0;
        #1;
        chk("s4_unblocked_s_req", s_req, 1);
        chk("s4_cnt_three", outst_cnt, 3);
        s_addr_ok = 1'b1; exp_acc(1, 32'h50, 32'h204);
        s_data_ok = 1'b1; s_rdata = 32'h201;
        cyc();
        drop(1); s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        #1 chk("s4_push_pop_cnt", outst_cnt, 3);
        data(32'h202); data(32'h203); data(32'h204);
        #1 chk("s4_drained_cnt", outst_cnt, 0);

        // Arbitration order with all three requesting; m2 accepted first to align the RR pointer.
        s_addr_ok = 1'b1;
        req(2, 1'b0, 32'h700, SIZE_WORD); exp_acc(2, 32'h700, 32'h300);
        cyc();
        drop(2); s_addr_ok = 1'b0;
        data(32'h300);
        for (int i = 0; i < 3; i++) req(i, 1'b0, 32'h600 + i, SIZE_WORD);
        s_addr_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef ARB_RR_EN
            rr_id = k % 3;
`else
            rr_id = 0;
`endif
            exp_acc(rr_id, 32'h600 + rr_id, 32'h900 + k);
            if (k > 0) begin
                s_data_ok = 1'b1;
                s_rdata   = 32'h900 + k - 1;
            end
            cyc();
        end
        for (int i = 0; i < 3; i++) drop(i);
        s_addr_ok = 1'b0;
        data(32'h905);

        // Unexpected data_ok, then reset with two requests in flight.
        s_data_ok = 1'b1; s_rdata = 32'hBAD;
        #1 chk("s6_no_data_ok", m_data_ok, 0);
        cyc();
        s_data_ok = 1'b0; s_rdata = '0;
        #1 chk("s6_err_set", err_unexp, 1);
        cyc(); cyc();
        chk("s6_err_held", err_unexp, 1);
        req(0, 1'b0, 32'h800, SIZE_WORD); s_addr_ok = 1'b1;
        exp_acc(0, 32'h800, 32'h0);
        cyc();
        exp_acc(0, 32'h800, 32'h0);
        cyc();
        s_addr_ok = 1'b0;
        #1 chk("s6_cnt_two", outst_cnt, 2);
        rst = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hFFFF_FFFF;
        exp_dq.delete();
        #1;
        chk("s6_rst_cnt", outst_cnt, 0);
        chk("s6_rst_err", err_unexp, 0);
        chk("s6_rst_s_req", s_req, 0);
        chk("s6_rst_addr_ok", m_addr_ok, 0);
        chk("s6_rst_data_ok", m_data_ok, 0);
        chk("s6_rst_rdata", m_rdata, 0);
        cyc();
        drop(0); s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0; rst = 1'b0;
        cyc();
        #1 chk("s6_post_rst_cnt", outst_cnt, 0);

        chk("end_addr_queue_empty", exp_aq.size(), 0);
        chk("end_data_queue_empty", exp_dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
